// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave bank of NUM_REGS software registers driving user logic, with an
// optional double-buffered mode where staged writes are committed atomically.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR            = 32'hFFFFFFFF,
    parameter logic [31:0] C_HIGHADDR            = 32'h00000000,
    parameter int          C_OPB_AWIDTH          = 32,
    parameter int          C_OPB_DWIDTH          = 32,
    parameter int          NUM_REGS              = 4,
    parameter int          C_DWIDTH_USER         = 32,
    parameter logic [31:0] C_INIT                = 32'h00000000,
    parameter bit          C_AUTO_COMMIT_DEFAULT = 1'b1
) (
    input  logic                              OPB_Clk,
    input  logic                              OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]           OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]         OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]           OPB_DBus,
    input  logic                              OPB_RNW,
    input  logic                              OPB_select,
    input  logic                              OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]           Sl_DBus,
    output logic                              Sl_xferAck,
    output logic                              Sl_errAck,
    output logic                              Sl_retry,
    output logic                              Sl_toutSup,
    output logic [NUM_REGS*C_DWIDTH_USER-1:0] user_data_out,
    output logic [NUM_REGS-1:0]               user_update
);

    localparam int AW = C_OPB_AWIDTH;
    localparam int DW = C_OPB_DWIDTH;
    localparam int NB = DW / 8;
    localparam int W  = C_DWIDTH_USER;

    localparam logic [AW-1:0] BASE = AW'(C_BASEADDR);
    localparam logic [AW-1:0] HIGH = AW'(C_HIGHADDR);

    logic [AW-1:0]       addr;
    logic [AW-1:0]       word_idx;
    logic                in_window;
    logic                hit;
    logic [NUM_REGS-1:0] reg_sel;
    logic                ctrl_sel;
    logic [DW-1:0]       rd_word;

    logic                ack_q;
    logic [DW-1:0]       rdata_q;
    logic                wr_q;
    logic [NUM_REGS-1:0] wsel_q;
    logic                wctrl_q;
    logic [DW-1:0]       wdata_q;
    logic [NB-1:0]       wbe_q;
    logic                auto_q;
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] update_q;
    logic [W-1:0]        shadow_q [NUM_REGS];
    logic [W-1:0]        out_q    [NUM_REGS];

    logic                unused_seq;

    assign unused_seq = OPB_seqAddr;

    // Big-endian bus vectors map MSB-to-MSB onto the little-endian internals.
    assign addr      = OPB_ABus;
    assign in_window = (addr >= BASE) && (addr <= HIGH);
    assign hit       = OPB_select && in_window && !ack_q;
    assign word_idx  = (addr - BASE) >> 2;

    always_comb begin
        reg_sel  = '0;
        rd_word  = '0;
        ctrl_sel = (word_idx == AW'(NUM_REGS));
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_sel[i] = (word_idx == AW'(i));
            if (reg_sel[i]) begin
                rd_word = DW'(shadow_q[i]);
            end
        end
        if (ctrl_sel) begin
            rd_word[1]             = auto_q;
            rd_word[2]             = |pending_q;
            rd_word[16 +: NUM_REGS] = pending_q;
        end
    end

    function automatic logic [W-1:0] merge_bytes(input logic [W-1:0]  old_val,
                                                 input logic [DW-1:0] data,
                                                 input logic [NB-1:0] be);
        logic [DW-1:0] m;
        m = DW'(old_val);
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                m[8*b +: 8] = data[8*b +: 8];
            end
        end
        return m[W-1:0];
    endfunction

    // Request is captured at the hit edge; the write itself lands at the ack edge.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            wr_q      <= 1'b0;
            wsel_q    <= '0;
            wctrl_q   <= 1'b0;
            wdata_q   <= '0;
            wbe_q     <= '0;
            auto_q    <= C_AUTO_COMMIT_DEFAULT;
            pending_q <= '0;
            update_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= C_INIT[W-1:0];
                out_q[i]    <= C_INIT[W-1:0];
            end
        end else begin
            ack_q    <= hit;
            rdata_q  <= (hit && OPB_RNW) ? rd_word : '0;
            wr_q     <= hit && !OPB_RNW;
            update_q <= '0;
            if (hit) begin
                wsel_q  <= reg_sel;
                wctrl_q <= ctrl_sel;
                wdata_q <= OPB_DBus;
                wbe_q   <= OPB_BE;
            end
            if (wr_q) begin
                if (wctrl_q) begin
                    auto_q <= wdata_q[1];
                    if (wdata_q[0]) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (pending_q[i]) begin
                                out_q[i] <= shadow_q[i];
                            end
                        end
                        update_q  <= pending_q;
                        pending_q <= '0;
                    end
                end
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wsel_q[i]) begin
                        shadow_q[i] <= merge_bytes(shadow_q[i], wdata_q, wbe_q);
                        if (auto_q) begin
                            out_q[i]     <= merge_bytes(shadow_q[i], wdata_q, wbe_q);
                            update_q[i]  <= 1'b1;
                            pending_q[i] <= 1'b0;
                        end else begin
                            pending_q[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign Sl_xferAck  = ack_q;
    assign Sl_DBus     = rdata_q;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_update = update_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign user_data_out[g*W +: W] = out_q[g];
    end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: directed vector table, hand sequences for
// handshake/reset corners, then randomized traffic against a behavioural model.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] A_BASE = 32'h4000_0000;
    localparam logic [31:0] A_HIGH = 32'h4000_003F;
    localparam logic [31:0] A_INIT = 32'h1234_5678;
    localparam logic [31:0] B_BASE = 32'h5000_0000;
    localparam logic [31:0] B_HIGH = 32'h5000_003F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:31] abus_s = '0;
    logic [0:3]  be_s = '0;
    logic [0:31] dbus_s = '0;
    logic        rnw_s = 1'b0;
    logic        sel_s = 1'b0;
    logic        seq_s = 1'b0;

    logic [0:31] dbusA, dbusB;
    logic        ackA, ackB, errA, errB, retA, retB, toA, toB;
    logic [127:0] outA;
    logic [23:0]  outB;
    logic [3:0]   updA;
    logic [1:0]   updB;
    logic         ack_any;
    logic [31:0]  dbus_any;

    assign ack_any  = ackA | ackB;
    assign dbus_any = dbusA | dbusB;

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(A_BASE), .C_HIGHADDR(A_HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
        .NUM_REGS(4), .C_DWIDTH_USER(32), .C_INIT(A_INIT), .C_AUTO_COMMIT_DEFAULT(1'b1)
    ) dut_a (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus_s), .OPB_BE(be_s),
        .OPB_DBus(dbus_s), .OPB_RNW(rnw_s), .OPB_select(sel_s), .OPB_seqAddr(seq_s),
        .Sl_DBus(dbusA), .Sl_xferAck(ackA), .Sl_errAck(errA), .Sl_retry(retA),
        .Sl_toutSup(toA), .user_data_out(outA), .user_update(updA)
    );

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(B_BASE), .C_HIGHADDR(B_HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
        .NUM_REGS(2), .C_DWIDTH_USER(12), .C_INIT(32'h0000_0ABC), .C_AUTO_COMMIT_DEFAULT(1'b0)
    ) dut_b (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus_s), .OPB_BE(be_s),
        .OPB_DBus(dbus_s), .OPB_RNW(rnw_s), .OPB_select(sel_s), .OPB_seqAddr(seq_s),
        .Sl_DBus(dbusB), .Sl_xferAck(ackB), .Sl_errAck(errB), .Sl_retry(retB),
        .Sl_toutSup(toB), .user_data_out(outB), .user_update(updB)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model of instance A.
    logic [31:0] sh_m  [4];
    logic [31:0] out_m [4];
    logic [3:0]  pend_m;
    bit          auto_m;
    bit          m_ack;
    logic [31:0] m_rd;
    logic [3:0]  m_upd;

    function automatic logic [127:0] model_out();
        return {out_m[3], out_m[2], out_m[1], out_m[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            sh_m[i]  = A_INIT;
            out_m[i] = A_INIT;
        end
        pend_m = '0;
        auto_m = 1'b1;
    endtask

    task automatic model_op(input logic [31:0] addr, input bit rnw,
                            input logic [0:3] be, input logic [31:0] data);
        int k;
        logic [31:0] nv;
        m_ack = 1'b0;
        m_rd  = '0;
        m_upd = '0;
        if (addr < A_BASE || addr > A_HIGH) return;
        m_ack = 1'b1;
        k = int'((addr - A_BASE) >> 2);
        if (rnw) begin
            if (k < 4)       m_rd = sh_m[k];
            else if (k == 4) m_rd = {12'b0, pend_m, 13'b0, (pend_m != 4'b0), auto_m, 1'b0};
        end else if (k < 4) begin
            nv = sh_m[k];
            for (int i = 0; i < 4; i++)
                if (be[i]) nv[31-8*i -: 8] = data[31-8*i -: 8];
            sh_m[k] = nv;
            if (auto_m) begin
                out_m[k]  = nv;
                m_upd[k]  = 1'b1;
                pend_m[k] = 1'b0;
            end else begin
                pend_m[k] = 1'b1;
            end
        end else if (k == 4) begin
            if (data[0]) begin
                for (int j = 0; j < 4; j++)
                    if (pend_m[j]) out_m[j] = sh_m[j];
                m_upd  = pend_m;
                pend_m = '0;
            end
            auto_m = data[1];
        end
    endtask

    task automatic xfer(input logic [31:0] addr, input bit rnw, input logic [0:3] be,
                        input logic [31:0] data, output logic [31:0] rd, output bit acked,
                        output logic [5:0] upd, output bit extra);
        @(posedge clk); #1;
        abus_s = addr; rnw_s = rnw; be_s = be; dbus_s = data; sel_s = 1'b1;
        acked = 1'b0; extra = 1'b0; rd = '0; upd = '0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                acked = ack_any;
                rd    = dbus_any;
                sel_s = 1'b0;
            end else if (ack_any || dbus_any != 32'b0) begin
                extra = 1'b1;
            end
            if (c == 2) upd = {updB, updA};
        end
    endtask

    task automatic do_op(input logic [31:0] addr, input bit rnw, input logic [0:3] be,
                         input logic [31:0] data, output logic [31:0] rd, output bit acked,
                         output logic [5:0] upd);
        bit extra;
        model_op(addr, rnw, be, data);
        xfer(addr, rnw, be, data, rd, acked, upd, extra);
        check("ack_idle_after_xfer", extra, 1'b0);
        check("user_data_out_a", outA, model_out());
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          rnw;
        logic [0:3]  be;
        logic [31:0] data;
        logic [31:0] exp_rd;
        bit          exp_ack;
        logic [5:0]  exp_upd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [31:0] a, input bit r, input logic [0:3] b,
                                input logic [31:0] d, input logic [31:0] er,
                                input bit ea, input logic [5:0] eu);
        vec_t v;
        v.addr = a; v.rnw = r; v.be = b; v.data = d;
        v.exp_rd = er; v.exp_ack = ea; v.exp_upd = eu;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        bit          acked;
        logic [5:0]  upd;
        logic [5:0]  ack_pat;
        logic [31:0] addr, data;
        bit          rnw;
        logic [0:3]  be;

        model_reset();

        tbl.push_back(mk(A_BASE+32'h00, 1, 4'hF, 0, A_INIT, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h04, 1, 4'hF, 0, A_INIT, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h08, 1, 4'hF, 0, A_INIT, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h0C, 1, 4'hF, 0, A_INIT, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h10, 1, 4'hF, 0, 32'h0000_0002, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h08, 0, 4'hF, 32'hDEAD_BEEF, 0, 1, 6'b000100));
        tbl.push_back(mk(A_BASE+32'h08, 1, 4'hF, 0, 32'hDEAD_BEEF, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h04, 0, 4'hF, 32'h1122_3344, 0, 1, 6'b000010));
        tbl.push_back(mk(A_BASE+32'h04, 0, 4'b0101, 32'hAABB_CCDD, 0, 1, 6'b000010));
        tbl.push_back(mk(A_BASE+32'h04, 1, 4'hF, 0, 32'h11BB_33DD, 1, 6'b0));
        tbl.push_back(mk(B_BASE+32'h00, 1, 4'hF, 0, 32'h0000_0ABC, 1, 6'b0));
        tbl.push_back(mk(B_BASE+32'h04, 0, 4'hF, 32'hFFFF_FFFF, 0, 1, 6'b0));
        tbl.push_back(mk(B_BASE+32'h04, 1, 4'hF, 0, 32'h0000_0FFF, 1, 6'b0));
        tbl.push_back(mk(B_BASE+32'h08, 1, 4'hF, 0, 32'h0002_0004, 1, 6'b0));
        tbl.push_back(mk(B_BASE+32'h08, 0, 4'hF, 32'h0000_0001, 0, 1, 6'b100000));
        tbl.push_back(mk(A_BASE+32'h10, 0, 4'hF, 32'h0000_0000, 0, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h00, 0, 4'hF, 32'h0000_0005, 0, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h0C, 0, 4'hF, 32'h0000_0009, 0, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h10, 1, 4'hF, 0, 32'h0009_0004, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h00, 1, 4'hF, 0, 32'h0000_0005, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h10, 0, 4'hF, 32'h0000_0001, 0, 1, 6'b001001));
        tbl.push_back(mk(A_BASE+32'h10, 1, 4'hF, 0, 32'h0000_0000, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h10, 0, 4'hF, 32'h0000_0001, 0, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h04, 0, 4'b0000, 32'hFFFF_FFFF, 0, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h10, 1, 4'hF, 0, 32'h0002_0004, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h10, 0, 4'hF, 32'h0000_0002, 0, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h10, 1, 4'hF, 0, 32'h0002_0006, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h10, 0, 4'hF, 32'h0000_0003, 0, 1, 6'b000010));
        tbl.push_back(mk(A_BASE+32'h10, 1, 4'hF, 0, 32'h0000_0002, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h04, 1, 4'hF, 0, 32'h11BB_33DD, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h20, 1, 4'hF, 0, 32'h0000_0000, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h24, 0, 4'hF, 32'hFFFF_FFFF, 0, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h14, 1, 4'hF, 0, 32'h0000_0000, 1, 6'b0));
        tbl.push_back(mk(A_BASE+32'h100, 1, 4'hF, 0, 32'h0000_0000, 0, 6'b0));
        tbl.push_back(mk(A_BASE+32'h100, 0, 4'hF, 32'h1234_0000, 0, 0, 6'b0));

        // Reset state, while held and after release.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack_any, 1'b0);
        check("rst_dbus", dbus_any, 32'h0);
        check("rst_out_a", outA, {4{A_INIT}});
        check("rst_out_b", outB, 24'hABC_ABC);
        check("rst_update", {updB, updA}, 6'b0);
        check("tieoffs", {errA, retA, toA, errB, retB, toB}, 6'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ack", ack_any, 1'b0);

        foreach (tbl[i]) begin
            do_op(tbl[i].addr, tbl[i].rnw, tbl[i].be, tbl[i].data, rd, acked, upd);
            check($sformatf("vec%0d_ack", i), acked, tbl[i].exp_ack);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_update", i), upd, tbl[i].exp_upd);
        end
        check("out_b_after_commit", outB, 24'hFFF_ABC);
        check("out_a_after_table", outA,
              {32'h0000_0009, 32'hDEAD_BEEF, 32'h11BB_33DD, 32'h0000_0005});

        // Select held continuously: acks must be spaced, never back to back.
        @(posedge clk); #1;
        abus_s = A_BASE; rnw_s = 1'b1; be_s = 4'hF; sel_s = 1'b1;
        ack_pat = '0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            ack_pat[c-1] = ack_any;
        end
        sel_s = 1'b0;
        check("held_select_ack_pattern", ack_pat, 6'b010101);
        @(posedge clk); #1;

        // Reset asserted while an ack is outstanding drops the write.
        abus_s = A_BASE + 32'h08; rnw_s = 1'b0; be_s = 4'hF; dbus_s = 32'hCAFE_F00D; sel_s = 1'b1;
        @(posedge clk); #1;
        check("inflight_ack_seen", ack_any, 1'b1);
        sel_s = 1'b0;
        rst_n = 1'b0;
        #1;
        check("inflight_rst_ack", ack_any, 1'b0);
        check("inflight_rst_out_a", outA, {4{A_INIT}});
        check("inflight_rst_out_b", outB, 24'hABC_ABC);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        ack_pat = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            ack_pat[c] = ack_any;
        end
        check("no_ack_after_reset", ack_pat, 6'b0);
        do_op(A_BASE + 32'h08, 1, 4'hF, 0, rd, acked, upd);
        check("reg2_after_reset", rd, A_INIT);
        do_op(A_BASE + 32'h10, 1, 4'hF, 0, rd, acked, upd);
        check("ctrl_after_reset", rd, 32'h0000_0002);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0)
                addr = A_BASE + 32'h40 + 4 * $urandom_range(0, 3);
            else
                addr = A_BASE + 4 * $urandom_range(0, 7);
            rnw  = ($urandom_range(0, 1) == 1);
            be   = 4'($urandom);
            data = $urandom;
            if (addr == A_BASE + 32'h10 && !rnw) data = $urandom_range(0, 3);
            do_op(addr, rnw, be, data, rd, acked, upd);
            check($sformatf("rnd%0d_ack", n), acked, m_ack);
            check($sformatf("rnd%0d_rdata", n), rd, m_rd);
            check($sformatf("rnd%0d_update", n), upd, {2'b00, m_upd});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
